psum_accumulator: RTL
=====================

PSUM_ACCUMULATOR -- requirements
Module: psum_accumulator

Interface
REQ-001 SHALL have parameter BW_PSUM, default 16, the signed width of each psum lane.
REQ-002 SHALL have parameter COL, default 8, the number of lanes per vector.
REQ-003 SHALL have parameter N_ACC, default 4, the number of input vectors summed per result (N_ACC>=1).
REQ-004 SHALL have port clk  input  1  the single clock; all state updates on the rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port in_valid  input  1  the input vector is valid this cycle.
REQ-007 SHALL have port in_psum  input  COL x BW_PSUM  the signed partial-sum vector from the array.
REQ-008 SHALL have port in_ready  output  1  the block accepts in_psum this cycle.
REQ-009 SHALL have port clear  input  1  synchronous discard of the partial accumulation.
REQ-010 SHALL have port ds_busy  input  1  the downstream normalizer cannot take a vector.
REQ-011 SHALL have port s_valid  output  1  one-cycle pulse marking a new result on psum.
REQ-012 SHALL have port psum  output  COL x BW_PSUM  the accumulated result vector.
REQ-013 SHALL have port acc_cnt  output  $clog2(N_ACC+1)  the beats accumulated so far.

Function
REQ-014 SHALL accept a beat on any rising edge where in_valid && in_ready are both high.
REQ-015 SHALL load acc = in_psum on the first beat (cnt==0) and acc = acc + in_psum per lane on later beats.
REQ-016 SHALL treat lane sums as signed and wrap modulo 2^BW_PSUM unless PSUM_SAT_EN is defined.
REQ-017 SHALL run a 2-state FSM: IDLE (cnt==0) goes to ACCUM on an accepted beat when N_ACC>1; ACCUM returns to IDLE on the N_ACC-th beat or on clear.
REQ-018 SHALL, on the N_ACC-th beat with no pending result and ds_busy low, load psum with the final sum and assert s_valid in the next cycle (1-cycle latency).
REQ-019 SHALL otherwise store the final sum in a hold register, set pending, and issue it (psum loaded, s_valid=1) on the first edge where ds_busy is sampled low.
REQ-020 SHALL hold s_valid high for exactly one cycle per result and keep psum stable until the next s_valid.
REQ-021 SHALL drive in_ready = !(pending && cnt==N_ACC-1); it SHALL never lose or overwrite a result.
REQ-022 SHALL give clear priority over a same-cycle beat: cnt and acc go to 0, the beat is dropped, and any pending result is kept.
REQ-023 SHALL issue results strictly in completion order (at most one pending plus one on psum).

Reset
REQ-024 SHALL, while reset is low, force s_valid=0, psum=0, acc=0, cnt=0, pending=0 and state=IDLE asynchronously; in_ready=1 after release.
REQ-025 SHALL discard any partial or pending result when reset is asserted mid-operation; no s_valid after release until N_ACC new beats arrive.

Configuration
REQ-026 SHALL, with PSUM_SAT_EN defined, clamp each lane sum to [-2^(BW_PSUM-1), 2^(BW_PSUM-1)-1]; without the macro, SHALL wrap it.

Structure
REQ-027 SHALL take BW_PSUM/COL defaults, the psum_vec_t packed typedef and the FSM state enum from shared package psum_pkg.
REQ-028 SHALL instantiate sub-module psum_add_lane (one signed adder, saturation per PSUM_SAT_EN) COL times.

Verification
REQ-029 SHALL check: 4 back-to-back beats with lane i = i, ds_busy=0 -> s_valid one cycle after the 4th beat, psum[i]=4*i.
REQ-030 SHALL check: ds_busy=1 with a result pending, then 4 more beats -> 3 accepted, in_ready=0 on the 4th; ds_busy drops -> first result issued, then second, each as a one-cycle s_valid.
REQ-031 SHALL check: lane 0 = 0x7000 on beats 1-2, 0 on beats 3-4 -> psum[0]=0xE000 without PSUM_SAT_EN, 0x7FFF with it; -0x7000 x2 -> 0x2000 or 0x8000.
REQ-032 SHALL check: clear after 2 beats, then 4 beats of 1 -> psum[i]=4, with no result from the aborted accumulation.
REQ-033 SHALL check: reset asserted after 3 beats -> outputs 0 immediately, and no s_valid until 4 fresh beats arrive.
REQ-034 SHALL check: random in_valid gaps (0-20 cycles) for 100 results against a reference model -> all results match and are in order.

Source files
------------

// File: rtl/psum_pkg.sv
// Shared definitions for the partial-sum accumulator: default lane geometry,
// the packed vector type and the accumulation FSM state encoding.
package psum_pkg;

    localparam int BW_PSUM_DEF = 16;
    localparam int COL_DEF     = 8;

    typedef logic signed [BW_PSUM_DEF-1:0] psum_lane_t;
    typedef psum_lane_t [COL_DEF-1:0]      psum_vec_t;

    // IDLE means no beats collected yet (cnt==0); ACCUM means a partial sum is live.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ACCUM = 1'b1
    } acc_state_t;

endpackage

// File: rtl/psum_add_lane.sv
// One signed lane adder. Optional macro PSUM_SAT_EN clamps the sum to the
// signed range of BW bits; without it the sum wraps modulo 2^BW.
module psum_add_lane #(
    parameter int BW = 16
) (
    input  logic signed [BW-1:0] a_i,
    input  logic signed [BW-1:0] b_i,
    output logic signed [BW-1:0] sum_o
);

`ifdef PSUM_SAT_EN
    logic signed [BW:0] full;

    // Add with one guard bit; clamp when the guard and sign bits disagree.
    always_comb begin
        full = {a_i[BW-1], a_i} + {b_i[BW-1], b_i};
        if (full[BW] != full[BW-1]) begin
            sum_o = full[BW] ? {1'b1, {(BW-1){1'b0}}} : {1'b0, {(BW-1){1'b1}}};
        end else begin
            sum_o = full[BW-1:0];
        end
    end
`else
    // Plain two's-complement add; overflow wraps.
    always_comb begin
        sum_o = a_i + b_i;
    end
`endif

endmodule

// File: rtl/psum_accumulator.sv
// Accumulates N_ACC partial-sum vectors per result and hands each result to a
// downstream normalizer that may stall (ds_busy). One finished result can wait
// in a hold register while the next accumulation proceeds; the final beat of
// that next accumulation is back-pressured until the hold register drains.
// Optional macro PSUM_SAT_EN selects saturating lane adds (default: wrap).
//
// Handshake: a beat is taken on a rising edge where in_valid && in_ready and
// clear is low; s_valid is a one-cycle pulse with psum held until the next one.
module psum_accumulator
    import psum_pkg::*;
#(
    parameter int BW_PSUM = BW_PSUM_DEF,
    parameter int COL     = COL_DEF,
    parameter int N_ACC   = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            in_valid,
    input  logic [COL-1:0][BW_PSUM-1:0]     in_psum,
    output logic                            in_ready,
    input  logic                            clear,
    input  logic                            ds_busy,
    output logic                            s_valid,
    output logic [COL-1:0][BW_PSUM-1:0]     psum,
    output logic [$clog2(N_ACC+1)-1:0]      acc_cnt,
    output acc_state_t                      state_dbg
);

    localparam int            CW       = $clog2(N_ACC + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(N_ACC - 1);

    acc_state_t                  state_q, state_d;
    logic [CW-1:0]               cnt_q, cnt_d;
    logic [COL-1:0][BW_PSUM-1:0] acc_q, acc_d;
    logic [COL-1:0][BW_PSUM-1:0] hold_q, hold_d;
    logic [COL-1:0][BW_PSUM-1:0] psum_q, psum_d;
    logic                        pending_q, pending_d;
    logic                        s_valid_q, s_valid_d;

    logic [COL-1:0][BW_PSUM-1:0] opa;
    logic [COL-1:0][BW_PSUM-1:0] sum_w;
    logic                        accept;
    logic                        last_beat;
    logic                        fin;

    // Beat qualification; the last beat is refused while a result still waits.
    always_comb begin
        last_beat = (cnt_q == LAST_CNT);
        in_ready  = !(pending_q && last_beat);
        accept    = in_valid && in_ready && !clear;
        fin       = accept && last_beat;
    end

    // First beat adds to zero so a single adder serves both load and accumulate.
    always_comb begin
        for (int i = 0; i < COL; i++) begin
            opa[i] = (cnt_q == '0) ? '0 : acc_q[i];
        end
    end

    for (genvar g = 0; g < COL; g++) begin : g_lane
        psum_add_lane #(.BW(BW_PSUM)) u_lane (
            .a_i   (opa[g]),
            .b_i   (in_psum[g]),
            .sum_o (sum_w[g])
        );
    end

    // Accumulator and beat counter; clear wins over a same-cycle beat.
    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        if (clear) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (accept) begin
            if (last_beat) begin
                acc_d = '0;
                cnt_d = '0;
            end else begin
                acc_d = sum_w;
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // Result issue: drain the hold register first, else issue a fresh sum directly.
    always_comb begin
        psum_d    = psum_q;
        s_valid_d = 1'b0;
        pending_d = pending_q;
        hold_d    = hold_q;
        if (pending_q && !ds_busy) begin
            psum_d    = hold_q;
            s_valid_d = 1'b1;
            pending_d = 1'b0;
        end
        // fin cannot coincide with pending_q because in_ready blocks it.
        if (fin) begin
            if (!pending_q && !ds_busy) begin
                psum_d    = sum_w;
                s_valid_d = 1'b1;
            end else begin
                hold_d    = sum_w;
                pending_d = 1'b1;
            end
        end
    end

    // Next-state logic for the IDLE/ACCUM tracker.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept && (N_ACC > 1)) begin
                    state_d = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (clear || fin) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            hold_q    <= '0;
            psum_q    <= '0;
            pending_q <= 1'b0;
            s_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            hold_q    <= hold_d;
            psum_q    <= psum_d;
            pending_q <= pending_d;
            s_valid_q <= s_valid_d;
        end
    end

    assign s_valid   = s_valid_q;
    assign psum      = psum_q;
    assign acc_cnt   = cnt_q;
    assign state_dbg = state_q;

endmodule
